// File: rtl/ne_frame_io_sequencer.sv
// Frame sequencer: load LLR beats, pulse start, await decoder_ready, unload hard decisions through a credit-checked FIFO.
// One frame at a time; optional decode watchdog under NE_FRAME_IOSEQ_TIMEOUT_EN.
module ne_frame_io_sequencer #(
  parameter int W              = 6,
  parameter int Nb             = 16,
  parameter int LOAD_BEATS     = 16,
  parameter int ADDRESSWIDTH   = 5,
  parameter int UNLOAD_BEATS   = 16,
  parameter int Kb             = 14,
  parameter int HDWIDTH        = 32,
  parameter int UNLOAD_LAT     = 2,
  parameter int OBUF_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TOCNTWIDTH     = 13
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [32*Nb*W-1:0]        in_data,
  output logic                      loaden,
  output logic [32*Nb*W-1:0]        load_data,
  output logic                      start,
  input  logic                      decoder_ready,
  output logic                      unload_en,
  output logic [ADDRESSWIDTH-1:0]   unloadAddress,
  input  logic [Kb*HDWIDTH-1:0]     unload_HDout_vec_regout,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [Kb*HDWIDTH-1:0]     out_data,
  output logic                      out_last,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      timeout_err
);
  localparam int HW  = Kb * HDWIDTH;
  localparam int LCW = (LOAD_BEATS > 1) ? $clog2(LOAD_BEATS) : 1;
  localparam int ICW = $clog2(UNLOAD_BEATS + 1);
  localparam int PCW = (UNLOAD_BEATS > 1) ? $clog2(UNLOAD_BEATS) : 1;
  localparam int PW  = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
  localparam int CW  = $clog2(OBUF_DEPTH + 1);
  localparam int IFW = $clog2(UNLOAD_LAT + 1);
  localparam int CRW = $clog2(OBUF_DEPTH + UNLOAD_LAT + 1);

  localparam logic [LCW-1:0] LOAD_LAST = LCW'(LOAD_BEATS - 1);
  localparam logic [ICW-1:0] UB        = ICW'(UNLOAD_BEATS);
  localparam logic [PCW-1:0] PUSH_LAST = PCW'(UNLOAD_BEATS - 1);
  localparam logic [PW-1:0]  PTR_LAST  = PW'(OBUF_DEPTH - 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, ARM, DECODE, UNLOAD} state_t;

  state_t                  state;
  logic [LCW-1:0]          load_cnt;
  logic                    arm_cnt;
  logic [ICW-1:0]          issued;
  logic [UNLOAD_LAT-1:0]   sr;
  logic [PCW-1:0]          push_cnt;
  logic [HW-1:0]           data_mem [OBUF_DEPTH];
  logic [OBUF_DEPTH-1:0]   last_mem;
  logic [PW-1:0]           rd_ptr, wr_ptr;
  logic [CW-1:0]           fifo_count;
  logic [IFW-1:0]          inflight;
  logic                    push, pop, issue, all_done, timeout_hit;

  // sr[0] mirrors unload_en, so the credit check covers every word not yet in the FIFO.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < UNLOAD_LAT; i++) inflight = inflight + IFW'(sr[i]);
  end

  assign push      = sr[UNLOAD_LAT-1];
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid & out_ready;
  assign out_data  = data_mem[rd_ptr];
  assign out_last  = last_mem[rd_ptr];
  assign busy      = (state != IDLE);
  assign issue     = (state == UNLOAD) && (issued != UB) &&
                     ((CRW'(fifo_count) + CRW'(inflight)) < CRW'(OBUF_DEPTH));
  assign all_done  = (state == UNLOAD) && (issued == UB) && (sr == '0) &&
                     (fifo_count == CW'(pop));

`ifdef NE_FRAME_IOSEQ_TIMEOUT_EN
  localparam logic [TOCNTWIDTH-1:0] TO_LAST = TOCNTWIDTH'(TIMEOUT_CYCLES - 1);
  logic [TOCNTWIDTH-1:0] to_cnt;

  assign timeout_hit = (state == DECODE) && !decoder_ready && (to_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      to_cnt <= (state == DECODE) ? to_cnt + 1'b1 : '0;
      if (timeout_hit) timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      in_ready      <= 1'b0;
      loaden        <= 1'b0;
      load_data     <= '0;
      start         <= 1'b0;
      unload_en     <= 1'b0;
      unloadAddress <= '0;
      frame_done    <= 1'b0;
      load_cnt      <= '0;
      arm_cnt       <= 1'b0;
      issued        <= '0;
    end else begin
      loaden     <= 1'b0;
      start      <= 1'b0;
      unload_en  <= 1'b0;
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          state    <= LOAD;
          in_ready <= 1'b1;
          load_cnt <= '0;
        end
        LOAD: if (in_valid && in_ready) begin
          loaden    <= 1'b1;
          load_data <= in_data;
          if (load_cnt == LOAD_LAST) begin
            in_ready <= 1'b0;
            load_cnt <= '0;
            state    <= START;
          end else begin
            load_cnt <= load_cnt + 1'b1;
          end
        end
        START: begin
          start   <= 1'b1;
          arm_cnt <= 1'b0;
          state   <= ARM;
        end
        // A decoder_ready level left over from the previous frame is ignored here.
        ARM: begin
          arm_cnt <= 1'b1;
          if (arm_cnt) state <= DECODE;
        end
        DECODE: begin
          issued <= '0;
          if (decoder_ready || timeout_hit) state <= UNLOAD;
        end
        UNLOAD: begin
          if (issue) begin
            unload_en     <= 1'b1;
            unloadAddress <= ADDRESSWIDTH'(issued);
            issued        <= issued + 1'b1;
          end
          if (all_done) begin
            frame_done <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr         <= '0;
      push_cnt   <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      last_mem   <= '0;
      for (int i = 0; i < OBUF_DEPTH; i++) data_mem[i] <= '0;
    end else begin
      for (int i = UNLOAD_LAT - 1; i > 0; i--) sr[i] <= sr[i-1];
      sr[0] <= issue;
      if (push) begin
        data_mem[wr_ptr] <= unload_HDout_vec_regout;
        last_mem[wr_ptr] <= (push_cnt == PUSH_LAST);
        wr_ptr           <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
        push_cnt         <= (push_cnt == PUSH_LAST) ? '0 : push_cnt + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end
endmodule
